// File: rtl/acs_survivor.sv
// acs_survivor: K=3 rate-1/2 Viterbi add-compare-select with per-frame survivor decision storage
module acs_survivor #(
  parameter int DATA_FRAME_LENGTH = 8,
  parameter int PM_WIDTH = 8
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           en_a,
  input  logic                           i_valid,
  input  logic [1:0]                     i_sym,
  output logic                           o_ready,
  output logic [DATA_FRAME_LENGTH*4-1:0] o_surv_dec,
  output logic [7:0]                     o_sel_node,
  output logic                           o_decoder_done
);
  localparam int CW = $clog2(DATA_FRAME_LENGTH);
  localparam logic [PM_WIDTH-1:0] PM_ZERO = PM_WIDTH'(0);
  localparam logic [PM_WIDTH-1:0] PM_INIT = PM_WIDTH'(63);
  localparam logic [CW-1:0] CNT_LAST = CW'(DATA_FRAME_LENGTH - 1);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state_q, state_d;
  logic [PM_WIDTH-1:0] pm_q [4];
  logic [PM_WIDTH-1:0] pm_d [4];
  logic [PM_WIDTH-1:0] cand0 [4];
  logic [PM_WIDTH-1:0] cand1 [4];
  logic [PM_WIDTH-1:0] acs [4];
  logic [3:0] dec;
  logic [1:0] best, sel_q, sel_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DATA_FRAME_LENGTH*4-1:0] surv_q, surv_d;

  function automatic logic [PM_WIDTH-1:0] add_bm(input logic [PM_WIDTH-1:0] pm, input logic [1:0] sym,
                                                  input logic u, input logic p1, input logic p0);
    logic [PM_WIDTH:0] s;
    s = {1'b0, pm} + (PM_WIDTH+1)'(sym[1] ^ u ^ p1 ^ p0) + (PM_WIDTH+1)'(sym[0] ^ u ^ p0);
    return s[PM_WIDTH] ? '1 : s[PM_WIDTH-1:0];
  endfunction

  always_comb begin
    best = 2'd0;
    for (int n = 0; n < 4; n++) begin
      cand0[n] = add_bm(pm_q[{n[0], 1'b0}], i_sym, n[1], n[0], 1'b0);
      cand1[n] = add_bm(pm_q[{n[0], 1'b1}], i_sym, n[1], n[0], 1'b1);
      dec[n] = cand1[n] < cand0[n];
      acs[n] = dec[n] ? cand1[n] : cand0[n];
    end
    for (int n = 1; n < 4; n++) best = acs[n] < acs[best] ? 2'(n) : best;
  end

  always_comb begin
    state_d = state_q;
    pm_d = pm_q;
    cnt_d = cnt_q;
    surv_d = surv_q;
    sel_d = sel_q;
    case (state_q)
      IDLE: if (en_a) begin
        state_d = RUN;
        pm_d = '{PM_ZERO, PM_INIT, PM_INIT, PM_INIT};
        cnt_d = '0;
        surv_d = '0;
        sel_d = 2'd0;
      end
      RUN: if (i_valid) begin
        pm_d = acs;
        cnt_d = cnt_q + 1'b1;
        surv_d[4*cnt_q +: 4] = dec;
        state_d = cnt_q == CNT_LAST ? DONE : RUN;
        sel_d = cnt_q == CNT_LAST ? best : sel_q;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      pm_q <= '{PM_ZERO, PM_INIT, PM_INIT, PM_INIT};
      cnt_q <= '0;
      surv_q <= '0;
      sel_q <= 2'd0;
    end else begin
      state_q <= state_d;
      pm_q <= pm_d;
      cnt_q <= cnt_d;
      surv_q <= surv_d;
      sel_q <= sel_d;
    end
  end

  assign o_ready = state_q == RUN;
  assign o_decoder_done = state_q == DONE;
  assign o_surv_dec = surv_q;
  assign o_sel_node = {6'd0, sel_q};
endmodule

// File: tb/tb_acs_survivor.sv
// tb_acs_survivor: randomized and directed frames checked against a trellis reference model
module tb_acs_survivor;
  localparam int L = 8;
  logic clk = 1'b0;
  logic rst, en_a, i_valid;
  logic [1:0] i_sym;
  logic o_ready, o_decoder_done;
  logic [L*4-1:0] o_surv_dec;
  logic [7:0] o_sel_node;
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  acs_survivor #(.DATA_FRAME_LENGTH(L), .PM_WIDTH(8)) dut (
    .clk(clk), .rst(rst), .en_a(en_a), .i_valid(i_valid), .i_sym(i_sym),
    .o_ready(o_ready), .o_surv_dec(o_surv_dec), .o_sel_node(o_sel_node),
    .o_decoder_done(o_decoder_done)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model(input logic [1:0] f [L], output logic [L*4-1:0] surv, output int sel, output int best);
    int pm [4];
    int nx [4];
    int c [2];
    int p, cw0, cw1, bm;
    pm = '{0, 63, 63, 63};
    surv = '0;
    for (int t = 0; t < L; t++) begin
      for (int n = 0; n < 4; n++) begin
        for (int k = 0; k < 2; k++) begin
          p = (n % 2) * 2 + k;
          cw0 = (n / 2) ^ (n % 2) ^ k;
          cw1 = (n / 2) ^ k;
          bm = (int'(f[t][1]) ^ cw0) + (int'(f[t][0]) ^ cw1);
          c[k] = pm[p] + bm > 255 ? 255 : pm[p] + bm;
        end
        surv[4*t+n] = c[1] < c[0];
        nx[n] = c[1] < c[0] ? c[1] : c[0];
      end
      pm = nx;
    end
    sel = 0;
    for (int n = 1; n < 4; n++) if (pm[n] < pm[sel]) sel = n;
    best = pm[sel];
  endtask

  task automatic frame(input logic [1:0] f [L], input int gap, input bit hold, input int exp_best);
    logic [L*4-1:0] es;
    int esel, eb;
    model(f, es, esel, eb);
    en_a = 1'b1;
    @(negedge clk);
    en_a = hold;
    for (int t = 0; t < L; t++) begin
      for (int g = 0; g < gap; g++) begin
        chk("ready_run", o_ready, 1);
        i_valid = 1'b0;
        i_sym = 2'($urandom);
        @(negedge clk);
      end
      chk("ready_run", o_ready, 1);
      i_valid = 1'b1;
      i_sym = f[t];
      @(negedge clk);
    end
    i_valid = 1'b0;
    i_sym = 2'($urandom);
    chk("done", o_decoder_done, 1);
    chk("ready_done", o_ready, 0);
    chk("sel", o_sel_node, 64'(esel));
    chk("surv", o_surv_dec, es);
    chk("best_pm", dut.pm_q[o_sel_node[1:0]], 64'(eb));
    if (exp_best >= 0) chk("best_spec", dut.pm_q[o_sel_node[1:0]], 64'(exp_best));
    @(negedge clk);
    chk("done_pulse", o_decoder_done, 0);
    chk("ready_idle", o_ready, 0);
    chk("surv_hold", o_surv_dec, es);
    chk("sel_hold", o_sel_node, 64'(esel));
  endtask

  initial begin
    logic [1:0] f [L];
    logic [1:0] z [L];
    logic [1:0] fx [L];
    #200000;
    $display("FAIL timeout got=%0d exp=%0d", checks, 0);
    $fatal(1, "timeout");
  end

  initial begin
    logic [1:0] f [L];
    logic [1:0] z [L];
    logic [1:0] fx [L];
    f = '{2'b11, 2'b10, 2'b00, 2'b01, 2'b01, 2'b11, 2'b00, 2'b00};
    z = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
    fx = f;
    fx[2] = 2'b10;
    rst = 1'b1;
    en_a = 1'b1;
    i_valid = 1'b1;
    i_sym = 2'b11;
    repeat (2) @(negedge clk);
    chk("rst_ready", o_ready, 0);
    chk("rst_done", o_decoder_done, 0);
    chk("rst_surv", o_surv_dec, 0);
    chk("rst_sel", o_sel_node, 0);
    rst = 1'b0;
    en_a = 1'b0;
    i_valid = 1'b0;
    @(negedge clk);
    chk("idle_ready", o_ready, 0);
    frame(z, 0, 1'b0, 0);
    chk("zero_state0_dec", o_surv_dec & 32'h1111_1111, 0);
    frame(f, 0, 1'b0, 0);
    frame(fx, 0, 1'b0, 1);
    frame(f, 3, 1'b0, 0);
    en_a = 1'b1;
    @(negedge clk);
    en_a = 1'b0;
    for (int t = 0; t < 4; t++) begin
      i_valid = 1'b1;
      i_sym = 2'($urandom);
      @(negedge clk);
    end
    rst = 1'b1;
    en_a = 1'b1;
    i_valid = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    en_a = 1'b0;
    i_valid = 1'b0;
    chk("mid_rst_ready", o_ready, 0);
    chk("mid_rst_done", o_decoder_done, 0);
    chk("mid_rst_surv", o_surv_dec, 0);
    chk("mid_rst_sel", o_sel_node, 0);
    chk("mid_rst_pm0", dut.pm_q[0], 0);
    chk("mid_rst_pm1", dut.pm_q[1], 63);
    @(negedge clk);
    chk("mid_rst_idle", o_ready, 0);
    frame(f, 0, 1'b0, 0);
    frame(f, 0, 1'b1, 0);
    frame(fx, 1, 1'b1, 1);
    en_a = 1'b0;
    @(negedge clk);
    chk("after_hold_idle", o_ready, 0);
    for (int r = 0; r < 20; r++) begin
      for (int t = 0; t < L; t++) f[t] = 2'($urandom);
      frame(f, int'($urandom_range(0, 2)), 1'($urandom), -1);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
